// File: rtl/led_colour_driver_if.sv
// Colour-code / LED bundle between the lighting state machine (master) and
// led_colour_driver (slave).
interface led_colour_driver_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          colour_i;
    logic                enable_i;
    logic [PWM_BITS-1:0] brightness_i;
    logic                led_r_o;
    logic                led_g_o;
    logic                led_b_o;
    logic                busy_o;
    logic                code_err_o;

    modport master (
        output colour_i, enable_i, brightness_i,
        input  led_r_o, led_g_o, led_b_o, busy_o, code_err_o
    );

    modport slave (
        input  colour_i, enable_i, brightness_i,
        output led_r_o, led_g_o, led_b_o, busy_o, code_err_o
    );
endinterface

// File: rtl/led_colour_driver.sv
// Decodes a 3-bit colour code into R/G/B PWM LED drives with global brightness.
// Define LED_FADE_EN to cross-fade channel levels; otherwise levels follow targets directly.
module led_colour_driver #(
    parameter int PWM_BITS         = 8,
    parameter int FADE_STEP_CYCLES = 4
) (
    input logic                clk,
    input logic                rst,
    led_colour_driver_if.slave bus
);
    typedef logic [PWM_BITS-1:0] level_t;

    if (FADE_STEP_CYCLES < 1) begin : gBadFadeStep
        $error("FADE_STEP_CYCLES must be at least 1");
    end

    logic   codeValid;
    level_t targetR, targetG, targetB;
    level_t pwmCnt_q, pwmCnt_d;
    level_t levelR_q, levelR_d;
    level_t levelG_q, levelG_d;
    level_t levelB_q, levelB_d;
    logic   ledR_q, ledR_d;
    logic   ledG_q, ledG_d;
    logic   ledB_q, ledB_d;
    logic   busy_q, busy_d;
    logic   codeErr_q, codeErr_d;

    function automatic level_t stepToward(level_t level, level_t target);
        if (level < target) begin
            return level + level_t'(1);
        end
        if (level > target) begin
            return level - level_t'(1);
        end
        return level;
    endfunction

    // Invalid codes and enable=0 both collapse every target to off.
    always_comb begin
        codeValid = (bus.colour_i != 3'b000) && (bus.colour_i != 3'b111);
        targetR   = (bus.enable_i && codeValid && bus.colour_i[2]) ? bus.brightness_i : '0;
        targetG   = (bus.enable_i && codeValid && bus.colour_i[1]) ? bus.brightness_i : '0;
        targetB   = (bus.enable_i && codeValid && bus.colour_i[0]) ? bus.brightness_i : '0;
    end

    always_comb begin
        pwmCnt_d  = pwmCnt_q + level_t'(1);
        ledR_d    = pwmCnt_q < levelR_q;
        ledG_d    = pwmCnt_q < levelG_d_unused_guard(levelG_q);
        ledB_d    = pwmCnt_q < levelB_q;
        codeErr_d = ~codeValid;
    end

    function automatic level_t levelG_d_unused_guard(level_t level);
        return level;
    endfunction

`ifdef LED_FADE_EN
    localparam int PRE_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
    typedef logic [PRE_W-1:0] pre_t;
    localparam pre_t PRE_LAST = pre_t'(FADE_STEP_CYCLES - 1);

    pre_t prescaler_q, prescaler_d;
    logic tick;

    // Levels move one LSB per prescaler tick, so a full-scale swing takes
    // 2^PWM_BITS-1 ticks and a mid-fade retarget simply reverses direction.
    always_comb begin
        tick        = (prescaler_q == PRE_LAST);
        prescaler_d = tick ? '0 : prescaler_q + pre_t'(1);
        levelR_d    = tick ? stepToward(levelR_q, targetR) : levelR_q;
        levelG_d    = tick ? stepToward(levelG_q, targetG) : levelG_q;
        levelB_d    = tick ? stepToward(levelB_q, targetB) : levelB_q;
        busy_d      = (levelR_q != targetR) | (levelG_q != targetG) | (levelB_q != targetB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end
`else
    always_comb begin
        levelR_d = targetR;
        levelG_d = targetG;
        levelB_d = targetB;
        busy_d   = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmCnt_q  <= '0;
            levelR_q  <= '0;
            levelG_q  <= '0;
            levelB_q  <= '0;
            ledR_q    <= 1'b0;
            ledG_q    <= 1'b0;
            ledB_q    <= 1'b0;
            busy_q    <= 1'b0;
            codeErr_q <= 1'b0;
        end else begin
            pwmCnt_q  <= pwmCnt_d;
            levelR_q  <= levelR_d;
            levelG_q  <= levelG_d;
            levelB_q  <= levelB_d;
            ledR_q    <= ledR_d;
            ledG_q    <= ledG_d;
            ledB_q    <= ledB_d;
            busy_q    <= busy_d;
            codeErr_q <= codeErr_d;
        end
    end

    assign bus.led_r_o    = ledR_q;
    assign bus.led_g_o    = ledG_q;
    assign bus.led_b_o    = ledB_q;
    assign bus.busy_o     = busy_q;
    assign bus.code_err_o = codeErr_q;
endmodule
